// File: rtl/alu_muldiv.sv
// Registered execute-stage ALU with an iterative multiply/divide unit and HI/LO registers.
// Single-cycle ops answer one cycle after acceptance. MULT/DIV keep the block busy for WIDTH+1 cycles.
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       Func_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    input  logic             upper,
    output logic             out_valid,
    output logic [WIDTH-1:0] O_out,
    output logic             Branch_out,
    output logic             Jump_out,
    output logic             busy_out,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;
    state_t r_state, w_next;

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_hi, r_lo, r_o;
    logic             r_out_valid, r_branch, r_jump;
    logic [WIDTH-1:0] r_acc, r_q, r_opnd;
    logic             r_is_div, r_neg_q, r_neg_r, r_div0;

    logic             w_accept, w_is_md, w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_sum, w_diff, w_a_mag, w_b_mag;
    logic [SHW-1:0]   w_sa;
    logic [WIDTH-1:0] w_sc_result;
    logic             w_sc_branch, w_sc_jump;
    logic [WIDTH:0]   w_mul_sum, w_rem_shift, w_rem_diff;
    logic [WIDTH-1:0] w_acc_nx, w_q_nx, w_quo_fix, w_rem_fix, w_fin_hi, w_fin_lo;
    logic [2*WIDTH-1:0] w_prod, w_prod_fix;

    assign w_accept = in_valid && (r_state == S_IDLE);
    assign w_is_md  = (Func_in[5:2] == 4'b0100);
    assign w_sum    = A_in + B_in;
    assign w_diff   = A_in - B_in;
    assign w_sa     = A_in[SHW-1:0];
    // Func_in[0] selects the unsigned variant; signed ops iterate on magnitudes.
    assign w_a_neg  = ~Func_in[0] & A_in[WIDTH-1];
    assign w_b_neg  = ~Func_in[0] & B_in[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -A_in : A_in;
    assign w_b_mag  = w_b_neg ? -B_in : B_in;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch
        w_next   = r_state;
        in_ready = 1'b0;
        busy_out = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy_out = 1'b0;
                if (w_accept && w_is_md) w_next = S_ITER;
            end
            S_ITER:  if (r_count == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_sc_result = '0;
        w_sc_branch = 1'b0;
        w_sc_jump   = 1'b0;
        casez (Func_in)
            6'b10000?: w_sc_result = w_sum;
            6'b10001?: w_sc_result = w_diff;
            6'b100100: w_sc_result = A_in & B_in;
            6'b100101: w_sc_result = A_in | B_in;
            6'b100110: w_sc_result = A_in ^ B_in;
            6'b100111: w_sc_result = ~(A_in | B_in);
            6'b101??0: w_sc_result = {{(WIDTH-1){1'b0}}, $signed(A_in) < $signed(B_in)};
            6'b101??1: w_sc_result = {{(WIDTH-1){1'b0}}, A_in < B_in};
            6'b110000: w_sc_result = B_in << w_sa;
            6'b110001: w_sc_result = B_in >> w_sa;
            6'b110010: w_sc_result = B_in;
            6'b110011: w_sc_result = $signed(B_in) >>> w_sa;
            6'b111???: begin
                w_sc_result = A_in;
                case (Func_in[2:0])
                    3'b000: w_sc_branch = A_in[WIDTH-1];
                    3'b001: w_sc_branch = ~A_in[WIDTH-1];
                    3'b010: w_sc_jump   = 1'b1;
                    3'b011: w_sc_jump   = 1'b1;
                    3'b100: w_sc_branch = (A_in == B_in);
                    3'b101: w_sc_branch = (A_in != B_in);
                    3'b110: w_sc_branch = A_in[WIDTH-1] | (A_in == '0);
                    3'b111: w_sc_branch = ~A_in[WIDTH-1] & (A_in != '0);
                endcase
            end
            6'b010100: w_sc_result = r_hi;
            6'b010101: w_sc_result = r_lo;
            6'b01011?: w_sc_result = A_in;
            default:   w_sc_result = '0;
        endcase
        if (upper) w_sc_result = w_sum << (WIDTH / 2);
    end

    // One iteration: multiply shifts {acc,q} right after a conditional add,
    // divide shifts the dividend into acc and keeps the subtraction if it stays non-negative.
    always_comb begin
        w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_opnd} : '0);
        w_rem_shift = {r_acc, r_q[WIDTH-1]};
        w_rem_diff  = w_rem_shift - {1'b0, r_opnd};
        if (r_is_div) begin
            if (!w_rem_diff[WIDTH]) begin
                w_acc_nx = w_rem_diff[WIDTH-1:0];
                w_q_nx   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nx = w_rem_shift[WIDTH-1:0];
                w_q_nx   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_nx = w_mul_sum[WIDTH:1];
            w_q_nx   = {w_mul_sum[0], r_q[WIDTH-1:1]};
        end
        w_prod     = {w_acc_nx, w_q_nx};
        w_prod_fix = r_neg_q ? -w_prod : w_prod;
        w_quo_fix  = r_div0 ? '1 : (r_neg_q ? -w_q_nx : w_q_nx);
        w_rem_fix  = r_neg_r ? -w_acc_nx : w_acc_nx;
        w_fin_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
        w_fin_lo   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking everywhere in clocked logic, so each flop samples pre-edge values
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count     <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_o         <= '0;
            r_out_valid <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            if (w_accept) begin
                if (w_is_md) begin
                    r_count <= '0;
                end else begin
                    r_out_valid <= 1'b1;
                    r_o         <= w_sc_result;
                    r_branch    <= w_sc_branch;
                    r_jump      <= w_sc_jump;
                    if (Func_in == 6'b010110) r_hi <= A_in;
                    if (Func_in == 6'b010111) r_lo <= A_in;
                end
            end else if (r_state == S_ITER) begin
                r_count <= r_count + CW'(1);
                if (r_count == LAST) begin
                    r_hi        <= w_fin_hi;
                    r_lo        <= w_fin_lo;
                    r_o         <= w_fin_lo;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end

    // NOTE: iteration scratch carries no reset; it is always loaded on accept before it is read
    always_ff @(posedge clk) begin
        if (w_accept && w_is_md) begin
            r_acc    <= '0;
            r_q      <= w_a_mag;
            r_opnd   <= w_b_mag;
            r_is_div <= Func_in[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= (B_in == '0);
        end else if (r_state == S_ITER) begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
        end
    end

    assign out_valid  = r_out_valid;
    assign O_out      = r_o;
    assign Branch_out = r_branch;
    assign Jump_out   = r_jump;
    assign hi_out     = r_hi;
    assign lo_out     = r_lo;
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: cycle-timed behavioural model, per-cycle compare,
// hand-computed directed cases and randomized traffic.
module tb_alu_muldiv;
    localparam int W = 32;

    localparam logic [5:0] F_ADD  = 6'b100000, F_SUB  = 6'b100010, F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101, F_XOR  = 6'b100110, F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101000, F_SLTU = 6'b101001, F_SLL  = 6'b110000;
    localparam logic [5:0] F_SRL  = 6'b110001, F_PASB = 6'b110010, F_SRA  = 6'b110011;
    localparam logic [5:0] F_BLTZ = 6'b111000, F_J    = 6'b111010, F_BEQ  = 6'b111100;
    localparam logic [5:0] F_BGTZ = 6'b111111;
    localparam logic [5:0] F_MULT = 6'b010000, F_MULTU = 6'b010001, F_DIV = 6'b010010;
    localparam logic [5:0] F_DIVU = 6'b010011, F_MFHI = 6'b010100, F_MFLO = 6'b010101;
    localparam logic [5:0] F_MTHI = 6'b010110, F_MTLO = 6'b010111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         upper = 1'b0;
    logic [5:0]   Func_in = '0;
    logic [W-1:0] A_in = '0;
    logic [W-1:0] B_in = '0;
    logic         in_ready, out_valid, Branch_out, Jump_out, busy_out;
    logic [W-1:0] O_out, hi_out, lo_out;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Func_in(Func_in), .A_in(A_in), .B_in(B_in), .upper(upper),
        .out_valid(out_valid), .O_out(O_out), .Branch_out(Branch_out), .Jump_out(Jump_out),
        .busy_out(busy_out), .hi_out(hi_out), .lo_out(lo_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference ALU: results straight from the op definitions.
    function automatic void alu_ref(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic [W-1:0] hi, input logic [W-1:0] lo, input logic u,
                                    output logic [W-1:0] o, output logic br, output logic j);
        logic signed [W-1:0] sa, sb;
        sa = a;
        sb = b;
        o = '0;
        br = 1'b0;
        j = 1'b0;
        casez (f)
            6'b10000?: o = a + b;
            6'b10001?: o = a - b;
            6'b100100: o = a & b;
            6'b100101: o = a | b;
            6'b100110: o = a ^ b;
            6'b100111: o = ~(a | b);
            6'b101??0: o = (sa < sb) ? 1 : 0;
            6'b101??1: o = (a < b) ? 1 : 0;
            6'b110000: o = b << a[4:0];
            6'b110001: o = b >> a[4:0];
            6'b110010: o = b;
            6'b110011: o = sb >>> a[4:0];
            6'b111???: begin
                o = a;
                case (f[2:0])
                    3'd0: br = (sa < 0);
                    3'd1: br = (sa >= 0);
                    3'd2, 3'd3: j = 1'b1;
                    3'd4: br = (a == b);
                    3'd5: br = (a != b);
                    3'd6: br = (sa <= 0);
                    default: br = (sa > 0);
                endcase
            end
            6'b010100: o = hi;
            6'b010101: o = lo;
            6'b01011?: o = a;
            default: o = '0;
        endcase
        if (u) o = (a + b) << (W / 2);
    endfunction

    // Reference multiply/divide, returns {HI, LO}.
    function automatic logic [2*W-1:0] md_ref(input logic [1:0] kind, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb;
        logic [2*W-1:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (kind)
            2'd0: r = 64'(sa * sb);
            2'd1: r = {32'b0, a} * {32'b0, b};
            2'd2: if (b == 0) r = {a, {W{1'b1}}}; else r = {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 0) r = {a, {W{1'b1}}}; else r = {a % b, a / b};
        endcase
        return r;
    endfunction

    // Cycle-timed model state: values expected in the cycle after each rising edge.
    int           m_cyc = 0;
    int           done_cyc = 0;
    logic         m_live = 1'b0, pend = 1'b0, m_acc = 1'b0;
    logic         m_ready = 1'b0, m_ov = 1'b0, m_br = 1'b0, m_j = 1'b0;
    logic [W-1:0] m_o = '0, m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

    initial forever begin
        @(posedge clk);
        m_cyc++;
        if (reset) begin
            pend = 1'b0; m_hi = '0; m_lo = '0; m_ov = 1'b0; m_br = 1'b0; m_j = 1'b0;
            m_ready = 1'b1; m_live = 1'b1;
        end else begin
            m_acc = in_valid && m_ready;
            m_ov = 1'b0; m_br = 1'b0; m_j = 1'b0;
            if (pend && m_cyc == done_cyc) begin
                m_hi = p_hi; m_lo = p_lo; m_o = p_lo; m_ov = 1'b1;
            end else if (pend && m_cyc > done_cyc) begin
                pend = 1'b0;
            end
            if (m_acc) begin
                if (Func_in[5:2] == 4'b0100) begin
                    {p_hi, p_lo} = md_ref(Func_in[1:0], A_in, B_in);
                    pend = 1'b1;
                    done_cyc = m_cyc + W;
                end else begin
                    alu_ref(Func_in, A_in, B_in, m_hi, m_lo, upper, m_o, m_br, m_j);
                    m_ov = 1'b1;
                    if (Func_in == F_MTHI) m_hi = A_in;
                    if (Func_in == F_MTLO) m_lo = A_in;
                end
            end
            m_ready = !pend;
        end
    end

    // Compare process: all outputs every cycle, result fields when valid.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("in_ready", in_ready, m_ready);
            check("busy_out", busy_out, pend);
            check("out_valid", out_valid, m_ov);
            check("hi_out", hi_out, m_hi);
            check("lo_out", lo_out, m_lo);
            check("branch_out", Branch_out, m_br);
            check("jump_out", Jump_out, m_j);
            if (m_ov) check("o_out", O_out, m_o);
        end
    end

    // Present a request at a falling edge and hold it until the edge that accepts it.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic u, output int waited);
        Func_in = f; A_in = a; B_in = b; upper = u; in_valid = 1'b1;
        waited = 0;
        while (!m_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 200) check("issue_accept_timeout", m_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] o, output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int busy_n, output logic seen);
        int w;
        issue(f, a, b, 1'b0, w);
        busy_n = 0; seen = 1'b0; o = '0; hi = '0; lo = '0;
        for (int t = 0; t < 100 && busy_out; t++) begin
            busy_n++;
            if (out_valid) begin
                seen = 1'b1; o = O_out; hi = hi_out; lo = lo_out;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [W-1:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return 1;
            2: return '1;
            3: return 32'h8000_0000;
            4: return W'($urandom_range(0, 40));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [5:0] rnd_op();
        case ($urandom_range(0, 31))
            0: return F_ADD;   1: return F_SUB;   2: return F_AND;   3: return F_OR;
            4: return F_XOR;   5: return F_NOR;   6: return F_SLT;   7: return F_SLTU;
            8: return F_SLL;   9: return F_SRL;  10: return F_PASB; 11: return F_SRA;
            12: return 6'b111000; 13: return 6'b111001; 14: return 6'b111010; 15: return 6'b111011;
            16: return 6'b111100; 17: return 6'b111101; 18: return 6'b111110; 19: return 6'b111111;
            20: return F_MULT; 21: return F_MULTU; 22: return F_DIV;  23: return F_DIVU;
            24: return F_MFHI; 25: return F_MFLO;  26: return F_MTHI; 27: return F_MTLO;
            default: return 6'($urandom);
        endcase
    endfunction

    int           w;
    int           busy_n;
    int           ov_seen;
    logic         seen;
    logic [W-1:0] c_o, c_hi, c_lo;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_o_out", O_out, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        reset = 1'b0;

        // Back-to-back single-cycle ops.
        issue(F_SUB, 32'd5, 32'd7, 1'b0, w);
        check("sub_valid", out_valid, 1);
        check("sub_result", O_out, 32'hFFFF_FFFE);
        check("model_sub", m_o, 32'hFFFF_FFFE);
        issue(F_SRA, 32'd4, 32'h8000_0000, 1'b0, w);
        check("sra_valid", out_valid, 1);
        check("sra_result", O_out, 32'hF800_0000);
        issue(F_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b0, w);
        check("sltu_result", O_out, 0);
        issue(F_SLT, 32'hFFFF_FFFF, 32'd1, 1'b0, w);
        check("slt_valid", out_valid, 1);
        check("slt_result", O_out, 1);

        // Signed multiply then MFHI.
        run_md(F_MULT, 32'hFFFF_FFFD, 32'd5, c_o, c_hi, c_lo, busy_n, seen);
        check("mult_busy_cycles", busy_n, 33);
        check("mult_valid_seen", seen, 1);
        check("mult_o", c_o, 32'hFFFF_FFF1);
        check("mult_hi", c_hi, 32'hFFFF_FFFF);
        check("mult_lo", c_lo, 32'hFFFF_FFF1);
        check("model_mult_hi", m_hi, 32'hFFFF_FFFF);
        issue(F_MFHI, 32'd0, 32'd0, 1'b0, w);
        check("mfhi_result", O_out, 32'hFFFF_FFFF);

        // Divides, divide by zero and signed overflow.
        run_md(F_DIV, 32'hFFFF_FFF9, 32'd2, c_o, c_hi, c_lo, busy_n, seen);
        check("div_lo", c_lo, 32'hFFFF_FFFD);
        check("div_hi", c_hi, 32'hFFFF_FFFF);
        run_md(F_DIVU, 32'd7, 32'd0, c_o, c_hi, c_lo, busy_n, seen);
        check("divu0_busy_cycles", busy_n, 33);
        check("divu0_lo", c_lo, 32'hFFFF_FFFF);
        check("divu0_hi", c_hi, 32'd7);
        run_md(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, c_o, c_hi, c_lo, busy_n, seen);
        check("divovf_lo", c_lo, 32'h8000_0000);
        check("divovf_hi", c_hi, 32'd0);
        check("model_divovf_lo", m_lo, 32'h8000_0000);

        // ADD held during a multiply is accepted only once in_ready returns.
        issue(F_MULT, 32'd3, 32'd4, 1'b0, w);
        issue(F_ADD, 32'd3, 32'd4, 1'b0, w);
        check("add_held_cycles", w, 33);
        check("add_after_mult_valid", out_valid, 1);
        check("add_after_mult_result", O_out, 32'd7);

        // Branch, jump and upper-immediate.
        issue(F_BEQ, 32'd12, 32'd12, 1'b0, w);
        check("beq_branch", Branch_out, 1);
        check("beq_o", O_out, 32'd12);
        issue(F_BGTZ, 32'd0, 32'd5, 1'b0, w);
        check("bgtz_zero_branch", Branch_out, 0);
        issue(F_J, 32'h40, 32'd0, 1'b0, w);
        check("j_jump", Jump_out, 1);
        issue(F_ADD, 32'd0, 32'h1234, 1'b1, w);
        check("upper_result", O_out, 32'h1234_0000);

        // Reset in the middle of a divide.
        issue(F_DIVU, 32'd1000, 32'd7, 1'b0, w);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy_out, 0);
        check("rst_hi", hi_out, 0);
        check("rst_lo", lo_out, 0);
        check("rst_valid", out_valid, 0);
        ov_seen = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("rst_no_late_valid", ov_seen, 0);
        issue(F_ADD, 32'd1, 32'd2, 1'b0, w);
        check("post_rst_add", O_out, 32'd3);

        // Randomized traffic checked by the compare process.
        for (int n = 0; n < 300; n++) begin
            issue(rnd_op(), rnd_opnd(), rnd_opnd(), ($urandom_range(0, 7) == 0), w);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
